// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed LSB-first serial transmitter; define SERIAL_TX_PARITY_EN for an even-parity bit
module serial_frame_tx #(
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] D_in,
    input  logic              load,
    output logic              ready,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);
    localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t            state, state_n;
    logic [TW-1:0]     timer, timer_n;
    logic [IW-1:0]     idx, idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              serial_n, done_n, tick, last;
`ifdef SERIAL_TX_PARITY_EN
    logic              par, par_n;
`endif

    assign tick  = timer == TW'(DIV - 1);
    assign last  = idx == IW'(DATA_W - 1);
    assign ready = state == IDLE;
    assign busy  = !ready;

    // Next-state logic; serial_out is computed from the next state so the line is a pure flop output
    always_comb begin
        state_n = state;
        timer_n = tick ? '0 : timer + TW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        done_n  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                timer_n = '0;
                if (load) begin
                    state_n = START;
                    shreg_n = D_in;
                    idx_n   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_n   = ^D_in;
`endif
                end
            end
            START: state_n = tick ? DATA : START;
            DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    idx_n   = last ? '0 : idx + IW'(1);
`ifdef SERIAL_TX_PARITY_EN
                    state_n = last ? PARITY : DATA;
`else
                    state_n = last ? STOP : DATA;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: state_n = tick ? STOP : PARITY;
`endif
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef SERIAL_TX_PARITY_EN
        serial_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PARITY ? par_n : 1'b1;
`else
        serial_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : 1'b1;
`endif
    end

    // State register; reset aborts any frame in progress without a done pulse
    always_ff @(posedge clock) begin
        if (Reset) begin
            state      <= IDLE;
            timer      <= '0;
            idx        <= '0;
            shreg      <= '0;
            serial_out <= 1'b1;
            done       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            serial_out <= serial_n;
            done       <= done_n;
`ifdef SERIAL_TX_PARITY_EN
            par        <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: randomized frame checks against a bit-list model, DIV=4 and DIV=1 instances
module tb_serial_frame_tx;
    typedef bit bitq_t[$];

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] data_a = '0, data_b = '0;
    logic       load_a = 1'b0, load_b = 1'b0;
    logic       ready_a, so_a, busy_a, done_a;
    logic       ready_b, so_b, busy_b, done_b;
    logic       so_s, busy_s, done_s, ready_s;
    int         cur = 0;
    int         tests = 0;
    int         fails = 0;

    always #5 clock = ~clock;

    serial_frame_tx #(.DATA_W(8), .DIV(4)) dut_a (
        .clock(clock), .Reset(Reset), .D_in(data_a), .load(load_a),
        .ready(ready_a), .serial_out(so_a), .busy(busy_a), .done(done_a)
    );

    serial_frame_tx #(.DATA_W(8), .DIV(1)) dut_b (
        .clock(clock), .Reset(Reset), .D_in(data_b), .load(load_b),
        .ready(ready_b), .serial_out(so_b), .busy(busy_b), .done(done_b)
    );

    // Observe whichever instance the current scenario targets
    always_comb begin
        so_s    = cur != 0 ? so_b    : so_a;
        busy_s  = cur != 0 ? busy_b  : busy_a;
        done_s  = cur != 0 ? done_b  : done_a;
        ready_s = cur != 0 ? ready_b : ready_a;
    end

    function automatic int div_of();
        return cur != 0 ? 1 : 4;
    endfunction

    // Line levels of one frame, one entry per bit: start, data LSB first, optional parity, stop
    function automatic bitq_t frame_bits(input logic [7:0] d);
        bitq_t q;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
        q.push_back(^d);
`endif
        q.push_back(1'b1);
        return q;
    endfunction

    task automatic drive(input logic l, input logic [7:0] d);
        if (cur != 0) begin
            load_b = l;
            data_b = d;
        end else begin
            load_a = l;
            data_a = d;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        load_a = 1'b1;
        load_b = 1'b1;
        data_a = 8'h5A;
        data_b = 8'h5A;
        repeat (2) @(negedge clock);
        tests++;
        if ({so_a, ready_a, busy_a, done_a, so_b, ready_b, busy_b, done_b} !== 8'b1100_1100) begin
            fails++;
            $display("FAIL reset_state: got a=%b%b%b%b b=%b%b%b%b want so,ready,busy,done=1100",
                     so_a, ready_a, busy_a, done_a, so_b, ready_b, busy_b, done_b);
        end
        load_a = 1'b0;
        load_b = 1'b0;
        Reset = 1'b0;
        @(negedge clock);
        tests++;
        if ({busy_a, busy_b, so_a, so_b} !== 4'b0011) begin
            fails++;
            $display("FAIL reset_load_ignored: busy a=%b b=%b so a=%b b=%b want busy 0, so 1",
                     busy_a, busy_b, so_a, so_b);
        end
    endtask

    // One frame on the selected instance; optional load pulse of 8'hFF during data bit 3
    task automatic test_frame(input int sel, input logic [7:0] d, input bit glitch);
        bitq_t bits;
        int    dv, len;
        cur  = sel;
        dv   = div_of();
        bits = frame_bits(d);
        len  = bits.size() * dv;
        @(negedge clock);
        tests++;
        if (ready_s !== 1'b1) begin
            fails++;
            $display("FAIL ready_before_load: got %b want 1", ready_s);
        end
        drive(1'b1, d);
        @(negedge clock);
        drive(1'b0, d);
        for (int k = 0; k <= len + 1; k++) begin
            logic [3:0] got, want;
            got  = {so_s, busy_s, done_s, ready_s};
            want = k < len ? {bits[k / dv], 3'b100} : k == len ? 4'b1011 : 4'b1001;
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL frame d=%h div=%0d cycle %0d: so,busy,done,ready got %b want %b",
                         d, dv, k, got, want);
            end
            if (glitch && k == 4 * dv) drive(1'b1, 8'hFF);
            if (glitch && k == 4 * dv + 1) drive(1'b0, 8'hFF);
            if (k <= len) @(negedge clock);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        cur = 0;
        d = 8'($urandom);
        @(negedge clock);
        drive(1'b1, d);
        @(negedge clock);
        drive(1'b0, d);
        repeat (2 * 4 + 1) @(negedge clock);
        tests++;
        if (busy_a !== 1'b1) begin
            fails++;
            $display("FAIL mid_frame_busy: got %b want 1", busy_a);
        end
        Reset = 1'b1;
        @(negedge clock);
        Reset = 1'b0;
        tests++;
        if ({so_a, busy_a, done_a, ready_a} !== 4'b1001) begin
            fails++;
            $display("FAIL reset_abort: so,busy,done,ready got %b want 1001",
                     {so_a, busy_a, done_a, ready_a});
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            tests++;
            if ({so_a, busy_a, done_a} !== 3'b100) begin
                fails++;
                $display("FAIL after_abort cycle %0d: so,busy,done got %b want 100", k,
                         {so_a, busy_a, done_a});
            end
        end
        test_frame(0, 8'h3C, 1'b0);
    endtask

    // Second load lands in the done cycle: exactly one idle-high cycle between frames
    task automatic test_back_to_back(input int sel, input logic [7:0] d1, input logic [7:0] d2);
        bitq_t b1, b2;
        bit    line[$];
        int    dv, l1, l2;
        cur = sel;
        dv  = div_of();
        b1  = frame_bits(d1);
        b2  = frame_bits(d2);
        foreach (b1[i]) for (int j = 0; j < dv; j++) line.push_back(b1[i]);
        l1 = line.size();
        line.push_back(1'b1);
        foreach (b2[i]) for (int j = 0; j < dv; j++) line.push_back(b2[i]);
        l2 = line.size();
        line.push_back(1'b1);
        @(negedge clock);
        drive(1'b1, d1);
        @(negedge clock);
        drive(1'b0, d1);
        for (int k = 0; k < line.size(); k++) begin
            logic [1:0] got, want;
            got  = {so_s, done_s};
            want = {line[k], k == l1 || k == l2};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL back_to_back div=%0d cycle %0d: so,done got %b want %b", dv, k, got, want);
            end
            if (k == l1) drive(1'b1, d2);
            if (k == l1 + 1) drive(1'b0, d2);
            @(negedge clock);
        end
        tests++;
        if ({so_s, busy_s, done_s} !== 3'b100) begin
            fails++;
            $display("FAIL back_to_back_end: so,busy,done got %b want 100", {so_s, busy_s, done_s});
        end
    endtask

    initial begin
        test_reset();
        test_frame(0, 8'hA5, 1'b0);
        test_frame(0, 8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) test_frame(0, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) test_frame(1, 8'($urandom), 1'b0);
        test_frame(1, 8'h00, 1'b0);
        test_frame(1, 8'hFF, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
        test_frame(0, 8'h07, 1'b0);
        test_frame(0, 8'h03, 1'b0);
`endif
        test_reset_mid_frame();
        test_back_to_back(1, 8'h81, 8'($urandom));
        test_back_to_back(1, 8'($urandom), 8'h81);
        test_back_to_back(0, 8'($urandom), 8'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
